br_resolve_unit: RTL and testbench

- Pipelined branch/jump resolution functional unit for the OoO core.
- Accepts issued branch, JAL and JALR uops from the branch reservation station. Evaluates the condition, computes target and link value, and flags mispredicts against the frontend prediction.
- Returns results to the CDB/ROB through a valid/ready pipeline of configurable depth.
- Supersedes the single-cycle combinational comparator: adds width parametrisation, jump kinds, target/mispredict logic, backpressure and flush.

---
 rtl/rv32i_types.sv | 36 +++
 rtl/br_cond_eval.sv | 57 +++++
 rtl/br_resolve_unit.sv | 192 +++++++++++++++++++
 tb/tb_br_resolve_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Shared RV32I micro-op encodings used by the execution units.
//
//   br_kind_t : control-transfer flavour of a branch-unit uop
//               (conditional branch, JAL, JALR).
//   cmpop_t   : branch comparison selector, numerically equal to the
//               B-type funct3 field. Encodings 3'b010 and 3'b011 are not
//               defined by the ISA and resolve as not-taken.
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        BR   = 2'b00,
        JAL  = 2'b01,
        JALR = 2'b10
    } br_kind_t;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b100,
        CMP_GE  = 3'b101,
        CMP_LTU = 3'b110,
        CMP_GEU = 3'b111
    } cmpop_t;

    // Size of one instruction in bytes; the link / fall-through PC is pc + this.
    localparam int unsigned INSN_BYTES = 4;

    // True for the unconditional kinds.
    function automatic logic is_jump(input logic [1:0] kind);
        return (kind == JAL) || (kind == JALR);
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// -----------------------------------------------------------------------------
// br_cond_eval
//   Combinational branch-condition evaluator.
//
//   Ports:
//     i_kind   [1:0]      br_kind_t of the uop
//     i_cmpop  [2:0]      cmpop_t (branch funct3)
//     i_a      [XLEN-1:0] operand rs1
//     i_b      [XLEN-1:0] operand rs2
//     o_taken             resolved direction
//
//   Jumps are always taken. Conditional branches compare signed or unsigned
//   according to cmpop; undefined cmpop values and undefined kinds give
//   not-taken.
// -----------------------------------------------------------------------------
module br_cond_eval
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_kind,
    input  logic [2:0]      i_cmpop,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_taken
);

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic                   w_br_taken;

    assign w_a_s = i_a;
    assign w_b_s = i_b;

    always_comb begin
        w_br_taken = 1'b0;
        case (i_cmpop)
            CMP_EQ:  w_br_taken = (i_a == i_b);
            CMP_NE:  w_br_taken = (i_a != i_b);
            CMP_LT:  w_br_taken = (w_a_s <  w_b_s);
            CMP_GE:  w_br_taken = (w_a_s >= w_b_s);
            CMP_LTU: w_br_taken = (i_a <  i_b);
            CMP_GEU: w_br_taken = (i_a >= i_b);
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        o_taken = 1'b0;
        if (i_kind == BR) begin
            o_taken = w_br_taken;
        end else if (is_jump(i_kind)) begin
            o_taken = 1'b1;
        end
    end

endmodule

// File: rtl/br_resolve_unit.sv
// -----------------------------------------------------------------------------
// br_resolve_unit
//   Pipelined branch / jump resolution unit. Evaluates the branch condition,
//   computes the resolved next PC and link value, and flags a mispredict
//   against the frontend prediction. Results return in issue order through a
//   valid/ready pipeline of STAGES (1 or 2) registers.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     flush                       drop everything in flight this edge
//     in_valid / in_ready         issue handshake
//     in_kind, in_cmpop           br_kind_t, cmpop_t
//     in_rs1, in_rs2              compare operands (rs1 also JALR base)
//     in_pc, in_imm               uop PC and sign-extended offset
//     in_pred_taken/_target       frontend prediction
//     in_rob_idx                  ROB tag
//     out_valid / out_ready       result handshake to the CDB
//     out_rob_idx, out_taken      tag and resolved direction
//     out_target                  resolved next PC (target or pc+4)
//     out_link                    pc+4 for rd of JAL/JALR
//     out_mispredict              redirect required
//
//   Each register stage advances when it is empty or its downstream stage
//   advances, so bubbles collapse and the unit sustains one uop per cycle.
// -----------------------------------------------------------------------------
module br_resolve_unit
    import rv32i_types::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 5,
    parameter int STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_kind,
    input  logic [2:0]           in_cmpop,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_pred_taken,
    input  logic [XLEN-1:0]      in_pred_target,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic                 out_taken,
    output logic [XLEN-1:0]      out_target,
    output logic [XLEN-1:0]      out_link,
    output logic                 out_mispredict
);

    // Final result as held in the output register.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 taken;
        logic [XLEN-1:0]      target;
        logic [XLEN-1:0]      link;
        logic                 mispredict;
    } br_res_t;

    // Stage-1 product: compare result and adds, prediction carried along.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 taken;
        logic [XLEN-1:0]      dest;
        logic [XLEN-1:0]      link;
        logic                 pred_taken;
        logic [XLEN-1:0]      pred_target;
    } br_s1_t;

    // Next-PC select and mispredict detection. A not-taken uop falls through
    // to the link address, so its prediction target is irrelevant.
    function automatic br_res_t resolve(input br_s1_t s);
        br_res_t r;
        r.rob_idx    = s.rob_idx;
        r.taken      = s.taken;
        r.link       = s.link;
        r.target     = s.taken ? s.dest : s.link;
        r.mispredict = (s.taken != s.pred_taken) ||
                       (s.taken && (s.dest != s.pred_target));
        return r;
    endfunction

    logic            w_taken;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_dest;
    logic [XLEN-1:0] w_link;
    br_s1_t          w_s1;

    logic            w_adv_out;
    logic            w_load_vld;
    br_res_t         w_res_nxt;

    logic            r_vld_out;
    br_res_t         r_res_out;

    // ---- stage 1: condition, target and link ----
    br_cond_eval #(
        .XLEN (XLEN)
    ) u_cond (
        .i_kind  (in_kind),
        .i_cmpop (in_cmpop),
        .i_a     (in_rs1),
        .i_b     (in_rs2),
        .o_taken (w_taken)
    );

    // JALR target drops bit 0 of rs1+imm; all sums wrap at XLEN bits.
    assign w_jalr_sum = in_rs1 + in_imm;
    assign w_dest     = (in_kind == JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                          : (in_pc + in_imm);
    assign w_link     = in_pc + XLEN'(INSN_BYTES);

    assign w_s1 = '{
        rob_idx:     in_rob_idx,
        taken:       w_taken,
        dest:        w_dest,
        link:        w_link,
        pred_taken:  in_pred_taken,
        pred_target: in_pred_target
    };

    assign w_adv_out = ~r_vld_out | out_ready;

    generate
        if (STAGES == 1) begin : g_one_stage
            assign in_ready   = ~flush & w_adv_out;
            assign w_load_vld = in_valid & in_ready;
            assign w_res_nxt  = resolve(w_s1);
        end else if (STAGES == 2) begin : g_two_stage
            logic   r_vld_p1;
            br_s1_t r_s1_p1;
            logic   w_adv_p1;

            assign w_adv_p1 = ~r_vld_p1 | w_adv_out;
            assign in_ready = ~flush & w_adv_p1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_p1 <= 1'b0;
                end else if (flush) begin
                    r_vld_p1 <= 1'b0;
                end else if (w_adv_p1) begin
                    r_vld_p1 <= in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (in_valid && in_ready) begin
                    r_s1_p1 <= w_s1;
                end
            end

            // ---- stage 2: next-PC select and mispredict ----
            assign w_load_vld = r_vld_p1;
            assign w_res_nxt  = resolve(r_s1_p1);
        end else begin : g_bad_stages
            $error("br_resolve_unit: STAGES must be 1 or 2");
        end
    endgenerate

    // ---- output register ----
    // Data only moves when a new result is loaded, which keeps out_* stable
    // while the CDB stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_out <= 1'b0;
            r_res_out <= '0;
        end else begin
            if (flush) begin
                r_vld_out <= 1'b0;
            end else if (w_adv_out) begin
                r_vld_out <= w_load_vld;
            end
            if (!flush && w_adv_out && w_load_vld) begin
                r_res_out <= w_res_nxt;
            end
        end
    end

    assign out_valid      = r_vld_out;
    assign out_rob_idx    = r_res_out.rob_idx;
    assign out_taken      = r_res_out.taken;
    assign out_target     = r_res_out.target;
    assign out_link       = r_res_out.link;
    assign out_mispredict = r_res_out.mispredict;

endmodule

// File: tb/tb_br_resolve_unit.sv
module tb_br_resolve_unit;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;
    localparam int P_STAGES  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [1:0]           in_kind = '0;
    logic [2:0]           in_cmpop = '0;
    logic [XLEN-1:0]      in_rs1 = '0;
    logic [XLEN-1:0]      in_rs2 = '0;
    logic [XLEN-1:0]      in_pc = '0;
    logic [XLEN-1:0]      in_imm = '0;
    logic                 in_pred_taken = 1'b0;
    logic [XLEN-1:0]      in_pred_target = '0;
    logic [ROB_IDX_W-1:0] in_rob_idx = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    logic                 out_taken;
    logic [XLEN-1:0]      out_target;
    logic [XLEN-1:0]      out_link;
    logic                 out_mispredict;

    always #5 clk = ~clk;

    br_resolve_unit #(
        .XLEN      (XLEN),
        .ROB_IDX_W (ROB_IDX_W),
        .STAGES    (P_STAGES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_cmpop       (in_cmpop),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .in_rob_idx     (in_rob_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rob_idx    (out_rob_idx),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_link       (out_link),
        .out_mispredict (out_mispredict)
    );

    typedef struct packed {
        logic [4:0]  rob;
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mis;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_out   = 0;
    logic       mon_ev;
    logic       mon_er;
    logic [4:0] rob_ctr = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // Architectural meaning of a branch uop.
    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pt, input logic [31:0] ptgt,
                                   input logic [4:0] rob);
        exp_t        m;
        logic        tk;
        logic [31:0] dest;
        tk = 1'b0;
        if (kind == 2'd0) begin
            case (op)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = ($signed(a) <  $signed(b));
                3'd5: tk = ($signed(a) >= $signed(b));
                3'd6: tk = (a <  b);
                3'd7: tk = (a >= b);
                default: tk = 1'b0;
            endcase
        end else begin
            tk = 1'b1;
        end
        dest     = (kind == 2'd2) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        m.rob    = rob;
        m.taken  = tk;
        m.link   = pc + 32'd4;
        m.target = tk ? dest : pc + 32'd4;
        m.mis    = (tk != pt) || (tk && (dest != ptgt));
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: a uop presented at cycle c is visible at the output from
    // cycle c+STAGES when it is the oldest; in_ready is high unless the unit
    // holds STAGES uops and the sink stalls, or a flush is active.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            mon_ev = 1'b0;
            if (exp_q.size() > 0) mon_ev = ((cyc - acc_q[0]) >= P_STAGES);
            mon_er = !flush && ((exp_q.size() < P_STAGES) || out_ready);
            chk("out_valid", 64'(out_valid), 64'(mon_ev));
            chk("in_ready", 64'(in_ready), 64'(mon_er));
            if (mon_ev && out_valid) begin
                chk("res_rob",    64'(out_rob_idx),    64'(exp_q[0].rob));
                chk("res_taken",  64'(out_taken),      64'(exp_q[0].taken));
                chk("res_target", 64'(out_target),     64'(exp_q[0].target));
                chk("res_link",   64'(out_link),       64'(exp_q[0].link));
                chk("res_mis",    64'(out_mispredict), 64'(exp_q[0].mis));
            end
            if (flush) begin
                exp_q.delete();
                acc_q.delete();
            end else begin
                if (mon_ev && out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    n_out++;
                end
                if (in_valid && mon_er) begin
                    exp_q.push_back(model(in_kind, in_cmpop, in_rs1, in_rs2, in_pc, in_imm,
                                          in_pred_taken, in_pred_target, in_rob_idx));
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] kind, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt, input logic [4:0] rob);
        in_kind = kind; in_cmpop = op; in_rs1 = a; in_rs2 = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
        in_rob_idx = rob;
    endtask

    task automatic rand_uop();
        logic [31:0] r;
        exp_t        e;
        in_kind  = 2'($urandom_range(0, 2));
        in_cmpop = 3'($urandom_range(0, 7));
        in_rs1   = $urandom;
        case ($urandom_range(0, 3))
            0:       in_rs2 = in_rs1;
            1:       in_rs2 = in_rs1 ^ 32'h8000_0000;
            2:       in_rs2 = in_rs1 + 32'd1;
            default: in_rs2 = $urandom;
        endcase
        in_pc  = $urandom & 32'hFFFF_FFFC;
        r      = $urandom;
        in_imm = {{20{r[11]}}, r[11:0]};
        in_pred_taken = 1'($urandom_range(0, 1));
        in_rob_idx    = rob_ctr;
        rob_ctr       = rob_ctr + 5'd1;
        e = model(in_kind, in_cmpop, in_rs1, in_rs2, in_pc, in_imm, 1'b0, 32'h0, 5'd0);
        in_pred_target = ($urandom_range(0, 1) == 1) ? e.target : $urandom;
    endtask

    // Issue one uop into an empty unit and check the result against fixed values.
    task automatic run_directed(input string tag, input logic [1:0] kind, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic pt, input logic [31:0] ptgt, input logic [4:0] rob,
                                input logic etk, input logic [31:0] etgt,
                                input logic [31:0] elink, input logic emis);
        int lat;
        drive(kind, op, a, b, pc, imm, pt, ptgt, rob);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(P_STAGES));
        if (lat != 0) begin
            chk({tag, "_rob"},    64'(out_rob_idx),    64'(rob));
            chk({tag, "_taken"},  64'(out_taken),      64'(etk));
            chk({tag, "_target"}, 64'(out_target),     64'(etgt));
            chk({tag, "_link"},   64'(out_link),       64'(elink));
            chk({tag, "_mis"},    64'(out_mispredict), 64'(emis));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic [31:0] snap_tgt;
        logic [4:0]  snap_rob;

        // Reset state
        #3;
        chk("rst_out_valid", 64'(out_valid),      64'(0));
        chk("rst_taken",     64'(out_taken),      64'(0));
        chk("rst_mis",       64'(out_mispredict), 64'(0));
        chk("rst_target",    64'(out_target),     64'(0));
        chk("rst_link",      64'(out_link),       64'(0));
        chk("rst_rob",       64'(out_rob_idx),    64'(0));
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_directed("blt",  2'd0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd1,
                     1'b1, 32'h120, 32'h104, 1'b1);
        run_directed("bltu", 2'd0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd2,
                     1'b0, 32'h104, 32'h104, 1'b0);
        run_directed("jalr", 2'd2, 3'b000, 32'h1003, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1006, 5'd3,
                     1'b1, 32'h1006, 32'h204, 1'b0);
        run_directed("undef", 2'd0, 3'b010, 32'h5, 32'h5, 32'h300, 32'h40, 1'b1, 32'h340, 5'd4,
                     1'b0, 32'h304, 32'h304, 1'b1);
        run_directed("jal_wrap", 2'd1, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4, 5'd5,
                     1'b1, 32'h4, 32'h0, 1'b0);

        // Back-to-back stream, then a 3-cycle sink stall
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_uop();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rand_uop();
        out_ready = 1'b0;
        @(negedge clk);
        snap_tgt = out_target;
        snap_rob = out_rob_idx;
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_ready", 64'(in_ready),  64'(0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_hold_valid",  64'(out_valid),   64'(1));
            chk("stall_hold_target", 64'(out_target),  64'(snap_tgt));
            chk("stall_hold_rob",    64'(out_rob_idx), 64'(snap_rob));
            chk("stall_hold_ready",  64'(in_ready),    64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_count", 64'(n_out - base), 64'(9));
        chk("stream_empty", 64'(exp_q.size()), 64'(0));

        // Flush with two uops in flight and a third offered
        out_ready = 1'b1;
        rand_uop(); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_uop();
        @(posedge clk); #1;
        rand_uop();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        run_directed("post_flush", 2'd0, 3'b000, 32'h77, 32'h77, 32'h400, 32'hFFFF_FFF0, 1'b1,
                     32'h3F0, 5'd9, 1'b1, 32'h3F0, 32'h404, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with stalls and occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            if (in_valid) rand_uop();
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset with a full pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_uop(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid),      64'(0));
        chk("arst_taken",     64'(out_taken),      64'(0));
        chk("arst_mis",       64'(out_mispredict), 64'(0));
        chk("arst_target",    64'(out_target),     64'(0));
        chk("arst_link",      64'(out_link),       64'(0));
        chk("arst_rob",       64'(out_rob_idx),    64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready",  64'(in_ready),  64'(1));
        chk("arst_no_result", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        run_directed("post_rst", 2'd0, 3'b111, 32'h10, 32'h20, 32'h800, 32'h100, 1'b1, 32'h900,
                     5'd17, 1'b0, 32'h804, 32'h804, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
